// File: rtl/sm3_pkg.sv
// Shared SM3 constants, round helper functions and the compression FSM state type.
// Imported by sm3_round and sm3_compress.
package sm3_pkg;

    localparam int SM3_ROUNDS = 64;

    localparam logic [255:0] SM3_IV = {
        32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
        32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
    };

    localparam logic [31:0] T_LOW  = 32'h79cc4519;
    localparam logic [31:0] T_HIGH = 32'h7a879d8a;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } sm3_state_e;

    // Rotate left; the upper half of the doubled word holds the wrapped result.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] ff_j(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic low);
        return low ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
    endfunction

    function automatic logic [31:0] gg_j(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic low);
        return low ? (x ^ y ^ z) : ((x & y) | (~x & z));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
    endfunction

endpackage

// File: rtl/sm3_round.sv
// One combinational SM3 compression round: (A..H, j, W_j, W'_j) -> next A..H.
// Word order of the 256-bit state is A in [255:224] down to H in [31:0].
module sm3_round
    import sm3_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [5:0]   j,
    input  logic [31:0]  w_j,
    input  logic [31:0]  w1_j,
    output logic [255:0] st_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic        low;
    logic [31:0] tj;
    logic [31:0] a12;
    logic [31:0] ss1, ss2;
    logic [31:0] tt1, tt2;

    always_comb begin
        {a, b, c, d, e, f, g, h} = st_in;
        low = (j < 6'd16);
        tj  = low ? T_LOW : T_HIGH;
        a12 = rotl32(a, 5'd12);
        // Only j[4:0] feeds the Tj rotation, so rounds 32..63 wrap around.
        ss1 = rotl32(a12 + e + rotl32(tj, j[4:0]), 5'd7);
        ss2 = ss1 ^ a12;
        tt1 = ff_j(a, b, c, low) + d + ss2 + w1_j;
        tt2 = gg_j(e, f, g, low) + h + ss1 + w_j;
        st_out = {tt1, a, rotl32(b, 5'd9), c, p0(tt2), e, rotl32(f, 5'd19), g};
    end

endmodule

// File: rtl/sm3_compress.sv
// Iterative SM3 compression CF(V, B): one round per clock, then V xor ABCDEFGH.
// msg/msg0 come straight from msg_expand and must be held by upstream for the whole run.
module sm3_compress
    import sm3_pkg::*;
#(
    parameter int ROUNDS = SM3_ROUNDS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [255:0]  v_in,
    input  logic [2175:0] msg,
    input  logic [2047:0] msg0,
    output logic          busy,
    output logic          done,
    output logic [255:0]  v_out
);

    localparam int CW = $clog2(ROUNDS);

    sm3_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [255:0]  abcd_q, abcd_d;
    logic [255:0]  vsave_q, vsave_d;
    logic [255:0]  vout_q, vout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [CW+4:0] w_idx;
    logic [31:0]   w_j;
    logic [31:0]   w1_j;
    logic [255:0]  round_out;

    assign w_idx = {cnt_q, 5'd0};
    assign w_j   = msg[w_idx +: 32];
    assign w1_j  = msg0[w_idx +: 32];

    sm3_round u_round (
        .st_in  (abcd_q),
        .j      (cnt_q),
        .w_j    (w_j),
        .w1_j   (w1_j),
        .st_out (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            abcd_q  <= '0;
            vsave_q <= '0;
            vout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abcd_q  <= abcd_d;
            vsave_q <= vsave_d;
            vout_q  <= vout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abcd_d  = abcd_q;
        vsave_d = vsave_q;
        vout_d  = vout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ROUND;
                    cnt_d   = '0;
                    abcd_d  = v_in;
                    vsave_d = v_in;
                    busy_d  = 1'b1;
                end
            end
            ST_ROUND: begin
                abcd_d = round_out;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(ROUNDS - 1)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                vout_d  = abcd_q ^ vsave_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign v_out = vout_q;

endmodule

// File: tb/tb_sm3_compress.sv
// Self-checking bench for sm3_compress: known SM3 vectors plus random blocks
// checked against a loop-based reference of the SM3 expansion and compression.
module tb_sm3_compress;

    typedef logic [31:0] w68_t [68];

    localparam logic [255:0] IV = {
        32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
        32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
    };
    localparam logic [255:0] ABC_DIGEST = {
        32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
        32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0
    };
    localparam logic [255:0] ABCD_DIGEST = {
        32'hdebe9ff9, 32'h2275b8a1, 32'h38604889, 32'hc18e5a4d,
        32'h6fdb70e5, 32'h387e5765, 32'h293dcba3, 32'h9c0c5732
    };
    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_ABCD = {16{32'h61626364}};
    localparam logic [511:0] BLK_PAD2 = {32'h80000000, 448'h0, 32'h00000200};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [255:0]  v_in;
    logic [2175:0] msg;
    logic [2047:0] msg0;
    logic          busy;
    logic          done;
    logic [255:0]  v_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm3_compress dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .v_in  (v_in),
        .msg   (msg),
        .msg0  (msg0),
        .busy  (busy),
        .done  (done),
        .v_out (v_out)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    // Message expansion; word 0 is the most significant word of the block.
    function automatic w68_t expand(input logic [511:0] blk);
        w68_t w;
        logic [31:0] x;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 68; i++) begin
            x = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
            w[i] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(w[i-13], 7) ^ w[i-6];
        end
        return w;
    endfunction

    function automatic logic [255:0] ref_cf(input logic [255:0] v, input logic [511:0] blk);
        w68_t w;
        logic [31:0] r [8];
        logic [31:0] ss1, ss2, tt1, tt2, tj, ffv, ggv;
        w = expand(blk);
        for (int i = 0; i < 8; i++) r[i] = v[255 - 32*i -: 32];
        for (int j = 0; j < 64; j++) begin
            tj = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rl(rl(r[0], 12) + r[4] + rl(tj, j), 7);
            ss2 = ss1 ^ rl(r[0], 12);
            if (j < 16) begin
                ffv = r[0] ^ r[1] ^ r[2];
                ggv = r[4] ^ r[5] ^ r[6];
            end else begin
                ffv = (r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]);
                ggv = (r[4] & r[5]) | (~r[4] & r[6]);
            end
            tt1 = ffv + r[3] + ss2 + (w[j] ^ w[j+4]);
            tt2 = ggv + r[7] + ss1 + w[j];
            r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
            r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4];
            r[4] = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
        end
        return {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]} ^ v;
    endfunction

    task automatic load_block(input logic [511:0] blk);
        w68_t w;
        w = expand(blk);
        for (int i = 0; i < 68; i++) msg[32*i +: 32] = w[i];
        for (int i = 0; i < 64; i++) msg0[32*i +: 32] = w[i] ^ w[i+4];
    endtask

    // Edges counted from the accepting edge inclusive up to the one raising done.
    task automatic run(input string tag, input logic [255:0] v, input logic [511:0] blk,
                       input bit clobber, output logic [255:0] res, output int edges);
        @(negedge clk);
        load_block(blk);
        v_in  = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        if (clobber) v_in = '1;
        check({tag, "_busy"}, busy, 1'b1);
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        res = v_out;
    endtask

    logic [255:0] res, res2, rv;
    logic [511:0] rb;
    int edges;
    int done_cnt;
    int done_at [$];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        v_in  = '0;
        msg   = '0;
        msg0  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_vout", v_out, '0);
        rst_n = 1'b1;

        run("abc", IV, BLK_ABC, 1'b0, res, edges);
        check("abc_digest", res, ABC_DIGEST);
        check("abc_latency", edges, 66);
        check("abc_busy_in_done", busy, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("vout_hold", v_out, ABC_DIGEST);

        run("abcd1", IV, BLK_ABCD, 1'b0, res, edges);
        run("abcd2", res, BLK_PAD2, 1'b0, res2, edges);
        check("abcd_chain_digest", res2, ABCD_DIGEST);

        run("clobber", IV, BLK_ABC, 1'b1, res, edges);
        check("vin_captured", res, ABC_DIGEST);

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
            for (int i = 0; i < 8; i++) rv[32*i +: 32] = $urandom;
            run("rand", rv, rb, 1'b0, res, edges);
            check($sformatf("rand%0d_digest", n), res, ref_cf(rv, rb));
        end

        // start held high: back-to-back runs, presses while busy ignored.
        @(negedge clk);
        load_block(BLK_ABC);
        v_in  = IV;
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 200) start = 1'b0;
            if (done) begin
                done_at.push_back(k);
                check($sformatf("held_digest_k%0d", k), v_out, ABC_DIGEST);
            end
        end
        check("held_done_count", done_at.size(), 4);
        if (done_at.size() > 0) check("held_first_done", done_at[0], 66);
        for (int i = 1; i < done_at.size(); i++)
            check($sformatf("held_interval%0d", i), done_at[i] - done_at[i-1], 66);

        // Reset mid-run (round 30), asynchronous with respect to the clock.
        @(negedge clk);
        v_in  = IV;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("midrun_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_vout", v_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_spurious_done", done_cnt, 0);
        check("idle_after_rst", busy, 1'b0);
        run("restart", IV, BLK_ABC, 1'b0, res, edges);
        check("restart_digest", res, ABC_DIGEST);
        check("restart_latency", edges, 66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm3_compress.md
Name: sm3_compress

Overview:
- Iterative SM3 compression function CF(V, B). Sits directly downstream of msg_expand.
- Consumes the 68 W words and 64 W' words produced by msg_expand, plus a 256-bit chaining value.
- Executes one round per clock over 64 rounds, then returns V(i+1) = ABCDEFGH xor V(i).
- The upstream block controller chains successive 512-bit blocks through it.

Parameters:
- ROUNDS, 64: number of compression rounds. Fixed by SM3; the parameter exists only for assertions and the bench, not for tuning.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- v_in  input  256  chaining value V(i); A = v_in[255:224] ... H = v_in[31:0]
- msg  input  2176  W_j at msg[32*j +: 32], j = 0..67 (msg_expand layout)
- msg0  input  2048  W'_j at msg0[32*j +: 32], j = 0..63
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; v_out valid
- v_out  output  256  V(i+1); same word order as v_in

Behaviour:
- Reset (async assert, sync release): state = IDLE, round counter = 0, A..H = 0, saved V = 0, v_out = 0, busy = 0, done = 0.
- Interface: one clock; reset is asynchronous and active-low (rst_n).
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - start = 1 at edge E0: load A..H from v_in, save v_in internally, counter = 0, go to ROUND, busy = 1.
  - start = 0: hold.
- ROUND: each edge applies round j = counter, then increments the counter.
  - SS1 = ((A<<<12) + E + (Tj<<<(j mod 32))) <<< 7; SS2 = SS1 xor (A<<<12).
  - TT1 = FF_j(A,B,C) + D + SS2 + W'_j; TT2 = GG_j(E,F,G) + H + SS1 + W_j.
  - D = C; C = B<<<9; B = A; A = TT1; H = G; G = F<<<19; F = E; E = P0(TT2).
  - Tj = 79cc4519 for j = 0..15, 7a879d8a for j = 16..63.
  - FF/GG: j < 16 is X^Y^Z. j ≥ 16: FF = majority, GG = (X&Y)|(~X&Z).
  - All additions mod 2^32. Rotation amount j mod 32 matters for j ≥ 32 (e.g. j = 33 rotates by 1).
  - After round 63 (edge E64): go to FINAL.
- FINAL (edge E65): v_out = {A..H} xor saved V; done = 1 for the following cycle; busy = 0; go to IDLE.
- Latency: done is visible in the cycle after edge E65, i.e. 66 edges from acceptance inclusive. A new start may be accepted in that same done cycle (back-to-back).
- Input holding: msg/msg0 are NOT captured. Upstream holds them stable from the start cycle through the done cycle. v_in is captured and may change after acceptance.
- start while busy: ignored, no queuing.
- v_out holds its last value until the next FINAL.
- Reset mid-operation: immediate return to the reset state; partial result discarded; no done pulse.

Decomposition:
- sm3_pkg:
  - SM3_IV (7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e)
  - T_LOW, T_HIGH
  - functions rotl32, ff_j, gg_j, p0
  - state enum
- One sub-module: sm3_round. Combinational: (A..H, j, W_j, W'_j) -> next A..H.
- The W/W' word select by counter stays in sm3_compress.

Test Plan:
- Padded "abc" block (616263800…018) through msg_expand, v_in = SM3_IV, pulse start -> done exactly 66 edges after acceptance; v_out = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- "abcd"×16 block with IV, then feed v_out back as v_in with padding block 80000000…0200 -> second v_out = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
- start held high for 200 cycles with the "abc" block -> one done every 66 cycles, identical results each time; extra start pulses while busy have no effect.
- rst_n dropped at round 30, then released and "abc" restarted -> busy = 0, done = 0, v_out = 0 asynchronously on assert; no spurious done; restarted result matches scenario 1.
- Change v_in to all-ones one cycle after acceptance of the "abc" run -> v_out still equals scenario 1 value, proving v_in is captured.
